// File: rtl/prbs6_checker.sv
// Self-synchronising checker for the 6-bit LFSR stream s(t) = s(t-1) ^ s(t-6).
// Seeds its history from six received bits, then flywheels on its own prediction and flags mismatches.
module prbs6_checker #(
    parameter int ERR_W       = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [0:0] {
        ST_SEED   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [2:0]       LOSS_LVL  = 3'(LOSS_THRESH);
    localparam logic [2:0]       SEED_FULL = 3'd6;
    localparam logic [ERR_W-1:0] CNT_ONE   = ERR_W'(1'b1);
    localparam logic [ERR_W-1:0] CNT_MAX   = {ERR_W{1'b1}};

    function automatic logic lfsr_pred(input logic [5:0] h);
        return h[5] ^ h[0];
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       hist_q, hist_d;
    logic [2:0]       seed_cnt_q, seed_cnt_d;
    logic [2:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             pred_s;
    logic [5:0]       seed_hist_s;
    logic [2:0]       seed_nxt_s;
    logic [2:0]       miss_inc_s;
    logic [ERR_W-1:0] cnt_nxt_s;

    // Next-state logic: seeding, flywheel prediction, leaky-bucket lock loss and error counting.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        cnt_nxt_s   = err_cnt_q;
        pred_s      = lfsr_pred(hist_q);
        seed_hist_s = {hist_q[4:0], in};
        seed_nxt_s  = (seed_cnt_q == SEED_FULL) ? SEED_FULL : seed_cnt_q + 3'd1;
        miss_inc_s  = miss_q + 3'd1;

        case (state_q)
            ST_SEED: begin
                hist_d     = seed_hist_s;
                seed_cnt_d = seed_nxt_s;
                // All-zero history is the LFSR lock-up state, so keep seeding past it.
                if ((seed_nxt_s == SEED_FULL) && (seed_hist_s != 6'd0)) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                end else begin
                    state_d  = ST_SEED;
                    locked_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                // Shift the prediction, not the input, so one bad bit costs one pulse.
                hist_d = {hist_q[4:0], pred_s};
                if (in != pred_s) begin
                    err_d     = 1'b1;
                    cnt_nxt_s = (err_cnt_q == CNT_MAX) ? CNT_MAX : err_cnt_q + CNT_ONE;
                    if (miss_inc_s == LOSS_LVL) begin
                        state_d    = ST_SEED;
                        locked_d   = 1'b0;
                        miss_d     = 3'd0;
                        seed_cnt_d = 3'd0;
                    end else begin
                        miss_d = miss_inc_s;
                    end
                end else begin
                    if (miss_q != 3'd0) begin
                        miss_d = miss_q - 3'd1;
                    end else begin
                        miss_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d  = ST_SEED;
                locked_d = 1'b0;
            end
        endcase

        if (clr_cnt) begin
            err_cnt_d = {ERR_W{1'b0}};
        end else begin
            err_cnt_d = cnt_nxt_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_SEED;
            hist_q     <= 6'd0;
            seed_cnt_q <= 3'd0;
            miss_q     <= 3'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= {ERR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            seed_cnt_q <= seed_cnt_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// Bench for prbs6_checker: vector table, directed corner sequences and a randomized run
// compared every cycle against a stream-level reference model (8-bit and 4-bit counter instances).
module tb_prbs6_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_s;
    logic       clr_s;
    logic       lock8, err8, lock4, err4;
    logic [7:0] cnt8;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    prbs6_checker #(.ERR_W(8), .LOSS_THRESH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .clr_cnt(clr_s),
        .locked(lock8), .err(err8), .err_cnt(cnt8)
    );

    prbs6_checker #(.ERR_W(4), .LOSS_THRESH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .clr_cnt(clr_s),
        .locked(lock4), .err(err4), .err_cnt(cnt4)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Upstream shifter: feedback num[5]^num[0], shift left, output num[5].
    logic [5:0] sh;

    // Reference model state, expressed over the received stream.
    bit   m_win[$];
    int   m_seen;
    bit   m_lock;
    int   m_miss;
    bit   m_err;
    int   m_cnt8;
    int   m_cnt4;

    typedef struct {
        bit in;
        bit clr;
        bit locked;
        bit err;
        int cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sh_next(output bit b);
        b  = sh[5];
        sh = {sh[4:0], sh[5] ^ sh[0]};
    endtask

    task automatic model_edge();
        bit expct;
        int ones;
        if (!rst_n) begin
            m_win.delete();
            m_seen = 0;
            m_lock = 1'b0;
            m_miss = 0;
            m_err  = 1'b0;
            m_cnt8 = 0;
            m_cnt4 = 0;
        end else begin
            m_err = 1'b0;
            if (!m_lock) begin
                m_win.push_back(in_s);
                if (m_win.size() > 6) void'(m_win.pop_front());
                if (m_seen < 6) m_seen++;
                ones = 0;
                foreach (m_win[i]) ones += int'(m_win[i]);
                if (m_seen == 6 && ones > 0) m_lock = 1'b1;
            end else begin
                // m_win[0] is the bit six samples back, m_win[5] the newest.
                expct = m_win[5] ^ m_win[0];
                m_win.push_back(expct);
                void'(m_win.pop_front());
                if (in_s != expct) begin
                    m_err  = 1'b1;
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_lock = 1'b0;
                        m_miss = 0;
                        m_seen = 0;
                    end
                end else if (m_miss > 0) begin
                    m_miss--;
                end
            end
            if (clr_s) begin
                m_cnt8 = 0;
                m_cnt4 = 0;
            end
        end
    endtask

    task automatic tick(input bit b);
        in_s = b;
        @(posedge clk);
        model_edge();
        #1;
        chk("locked8", int'(lock8), int'(m_lock));
        chk("err8",    int'(err8),  int'(m_err));
        chk("cnt8",    int'(cnt8),  m_cnt8);
        chk("locked4", int'(lock4), int'(m_lock));
        chk("err4",    int'(err4),  int'(m_err));
        chk("cnt4",    int'(cnt4),  m_cnt4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_s = 1'b0;
        tick(1'b1);
        chk("rst_locked", int'(lock8), 0);
        chk("rst_err",    int'(err8),  0);
        chk("rst_cnt",    int'(cnt8),  0);
        rst_n = 1'b1;
        sh    = 6'b000001;
    endtask

    task automatic clean(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            sh_next(b);
            tick(b);
        end
    endtask

    initial begin
        bit b;
        int pulses;
        int drop;
        int pidx;
        int r;
        int burst;

        // Stream from seed 000001: 0 0 0 0 0 1 1 1 1 1 1 0 1 0 ...
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0};

        rst_n = 1'b0;
        in_s  = 1'b0;
        clr_s = 1'b0;
        sh    = 6'b000001;
        burst = 0;
        do_reset();
        do_reset();

        // Acquisition, single error, and clear-beats-increment from the vector table.
        for (int i = 0; i < 14; i++) begin
            clr_s = tbl[i].clr;
            sh_next(b);
            tick(tbl[i].in);
            clr_s = 1'b0;
            chk("tbl_locked", int'(lock8), int'(tbl[i].locked));
            chk("tbl_err",    int'(err8),  int'(tbl[i].err));
            chk("tbl_cnt",    int'(cnt8),  tbl[i].cnt);
            chk("tbl_cnt4",   int'(cnt4),  tbl[i].cnt);
        end

        // Clean stream over ten periods.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 630; k++) begin
            sh_next(b);
            tick(b);
            if (k == 5) chk("clean_lock_edge6", int'(lock8), 1);
            if (err8) pulses++;
        end
        chk("clean_pulses", pulses, 0);
        chk("clean_cnt", int'(cnt8), 0);
        chk("clean_locked", int'(lock8), 1);

        // Single inverted bit at stream index 100.
        do_reset();
        pulses = 0;
        drop   = 0;
        pidx   = -1;
        for (int k = 0; k < 200; k++) begin
            sh_next(b);
            tick((k == 100) ? ~b : b);
            if (err8) begin
                pulses++;
                pidx = k;
            end
            if (k >= 5 && !lock8) drop++;
        end
        chk("flip_pulses", pulses, 1);
        chk("flip_index", pidx, 100);
        chk("flip_cnt", int'(cnt8), 1);
        chk("flip_lockdrop", drop, 0);

        // Constant zero input never locks.
        do_reset();
        pulses = 0;
        drop   = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1'b0);
            if (err8) pulses++;
            if (lock8) drop++;
        end
        chk("zero_pulses", pulses, 0);
        chk("zero_lockseen", drop, 0);
        chk("zero_cnt", int'(cnt8), 0);

        // Four consecutive inverted bits lose lock; clean stream relocks 6 edges later.
        do_reset();
        clean(20);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            sh_next(b);
            tick(~b);
            if (err8) pulses++;
            if (k == 2) chk("burst_still_locked", int'(lock8), 1);
        end
        chk("burst_pulses", pulses, 4);
        chk("burst_cnt", int'(cnt8), 4);
        chk("burst_unlocked", int'(lock8), 0);
        for (int k = 0; k < 6; k++) begin
            sh_next(b);
            tick(b);
            if (k == 4) chk("relock_early", int'(lock8), 0);
        end
        chk("relock_6", int'(lock8), 1);

        // Saturation of the 4-bit counter with isolated errors; lock holds.
        do_reset();
        clean(10);
        pulses = 0;
        drop   = 0;
        for (int k = 0; k < 200; k++) begin
            sh_next(b);
            tick((k % 10 == 0) ? ~b : b);
            if (err4) pulses++;
            if (!lock4) drop++;
        end
        chk("sat_pulses", pulses, 20);
        chk("sat_cnt4", int'(cnt4), 15);
        chk("sat_cnt8", int'(cnt8), 20);
        chk("sat_lockdrop", drop, 0);
        clean(5);
        chk("sat_hold", int'(cnt4), 15);
        clr_s = 1'b1;
        sh_next(b);
        tick(~b);
        clr_s = 1'b0;
        chk("clr_cnt4", int'(cnt4), 0);
        chk("clr_cnt8", int'(cnt8), 0);
        chk("clr_err", int'(err4), 1);

        // One-edge reset while locked with three counted errors.
        do_reset();
        clean(10);
        for (int k = 0; k < 21; k++) begin
            sh_next(b);
            tick((k % 10 == 0) ? ~b : b);
        end
        chk("pre_rst_cnt", int'(cnt8), 3);
        chk("pre_rst_err", int'(err8), 1);
        rst_n = 1'b0;
        sh_next(b);
        tick(b);
        rst_n = 1'b1;
        chk("mid_rst_locked", int'(lock8), 0);
        chk("mid_rst_err", int'(err8), 0);
        chk("mid_rst_cnt", int'(cnt8), 0);
        sh = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            sh_next(b);
            tick(b);
            if (k == 4) chk("rst_relock_early", int'(lock8), 0);
        end
        chk("rst_relock_6", int'(lock8), 1);

        // Randomized: sparse flips, random bursts, random clears and resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r     = $urandom_range(0, 999);
            clr_s = ($urandom_range(0, 49) == 0);
            if (r < 5) begin
                rst_n = 1'b0;
                tick(1'b0);
                rst_n = 1'b1;
                sh    = 6'b000001;
            end else begin
                if (r < 20) burst = $urandom_range(3, 8);
                sh_next(b);
                if (burst > 0) begin
                    burst--;
                    tick(1'($urandom_range(0, 1)));
                end else begin
                    tick((r < 50) ? ~b : b);
                end
            end
        end
        clr_s = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prbs6_checker.md
# prbs6_checker

Serial receiver/checker for the 6-bit LFSR pattern stream (feedback `num[5]^num[0]`, shift-left, serial output `num[5]`, period 63). It sits directly downstream of the LFSR shifter and consumes its one-bit-per-clock `out` stream. It self-synchronises by seeding from the first six received bits, then predicts each subsequent bit and flags mismatches. It also counts errors and drops and re-acquires lock when errors accumulate.

## Interface
- `ERR_W`, default 8: width of the saturating error counter.
- `LOSS_THRESH`, default 4: leaky-bucket level at which lock is declared lost (range 1..7).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `in`  input  1  serial pattern bit, one new bit per clock (connects to the shifter's `out`).
- `clr_cnt`  input  1  synchronous clear of `err_cnt`.
- `locked`  output  1  1 while in LOCKED state (registered).
- `err`  output  1  one-cycle pulse; 1 when the bit sampled on the previous edge mismatched while locked (registered).
- `err_cnt`  output  ERR_W  saturating count of mismatches since reset or last clear (registered).

## Operation
- Recurrence checked: `s(t) = s(t-1) ^ s(t-6)`.
- History register `hist[5:0]`:
  - `hist[0]` holds the newest bit and `hist[5]` the bit from six samples ago.
  - `pred = hist[5] ^ hist[0]`.
- States: SEED, LOCKED.
- SEED:
  - Shift `in` into `hist` each cycle.
  - `seed_cnt` (3-bit) increments and saturates at 6.
  - Transition to LOCKED on the edge where the sixth bit is shifted in (`seed_cnt` reaches 6) if the new `hist` is nonzero.
  - If the new `hist` is all-zero, stay in SEED and re-evaluate every following edge, since all-zero is the LFSR lock-up state.
  - No `err` pulses and no counting in SEED.
- LOCKED (flywheel):
  - Compare `in` with `pred` and shift `pred` (not `in`) into `hist`, so one corrupted bit yields exactly one `err` pulse.
  - On mismatch: `err<=1`, `err_cnt` increments (saturating at all-ones), `miss` increments.
  - On match: `err<=0`, `miss` decrements, floor 0.
  - `miss` is 3 bits.
  - When a mismatch makes `miss == LOSS_THRESH`, on that same edge:
    - state goes to SEED, `locked<=0`, `miss<=0`, `seed_cnt<=0`;
    - `err` still pulses and `err_cnt` still increments for that bit.
- `clr_cnt`: `err_cnt<=0` and takes priority over a simultaneous increment. `err` is unaffected.
- Reset (`rst_n==0` at an edge), regardless of state:
  - `locked=0`, `err=0`, `err_cnt=0`, `hist=0`, `miss=0`, `seed_cnt=0`, state SEED.
  - `in` is ignored on that edge.

## Timing
- All outputs are registered; no combinational path from `in` to any output.
- Acquisition: after reset deasserts, bits b0..b5 are sampled on edges 1..6, and `locked` rises after edge 6 (when `hist` is nonzero).
- b6 is the first checked bit (edge 7); its `err` is visible after edge 7.
- Check latency: `err` and `err_cnt` reflect bit `b(k)` in the cycle after the edge that samples it.
- Loss of lock: `locked` falls after the edge that samples the LOSS_THRESH-th net mismatch. Re-lock takes a minimum of 6 further edges.
- Reset asserted mid-lock for a single edge returns all outputs to reset values after that edge. Normal re-acquisition follows.
- Interop: the shifter resets asynchronously. The bench must hold `rst_n` low across at least one rising edge so this block also resets.

## Test plan
- Clean stream, shifter seeded 000001 (stream 0,0,0,0,0,1,1,…):
  - `locked=1` after edge 6;
  - `err` never 1 over 630 cycles;
  - `err_cnt=0`.
- Lock, then invert a single bit at stream index 100:
  - exactly one `err` pulse, in the cycle after that bit is sampled;
  - `err_cnt=1`;
  - `locked` stays 1.
- Constant `in=0` for 100 cycles after reset:
  - `locked` stays 0, `err` stays 0, `err_cnt=0`.
- Lock, then drive `in=~expected` for 4 consecutive bits:
  - 4 `err` pulses;
  - `err_cnt=4`;
  - `locked=0` after the 4th;
  - resume the clean stream, and `locked=1` exactly 6 edges later.
- `ERR_W=4`:
  - inject 20 isolated bit errors spaced 10 bits apart → `err_cnt` saturates and holds at 15, `locked` stays 1;
  - assert `clr_cnt` on a cycle with a mismatch → `err_cnt=0`.
- Pull `rst_n` low for one edge while locked with `err_cnt=3`:
  - next cycle `locked=0`, `err=0`, `err_cnt=0`;
  - re-lock 6 edges after release.
